dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed, big-endian data memory between NUM_REQ requesters, e.g. the pipeline MEM stage and the debug/program-loader port.
- Arbitrates round-robin and latches the winning request.
- Drives the memory command bus (2'b10 read, 2'b01 write, word/byte select), then returns read data with a one-cycle ack pulse.
- Sits between the requesters and the data memory; the memory itself is unchanged.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_BYTES, 32: memory size in bytes; used only by the optional check.

Ports:
- clk  in  1  system clock; memory writes on posedge and reads on negedge of the same clk.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  1 = store, 0 = load.
- req_byte  in  NUM_REQ  1 = byte access, 0 = word access.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened store data.
- gnt  out  NUM_REQ  one-hot; high for the ISSUE cycle of the granted requester.
- ack  out  NUM_REQ  one-hot; one-cycle pulse when the access completes.
- rsp_rdata  out  DATA_W  load data; valid while ack is high, held until the next ack.
- rsp_err  out  1  error flag qualified by ack; meaningful only with the optional feature.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_cmd  out  2  to Mem_Write_Read; 00 idle, 01 write, 10 read.
- mem_word_byte  out  1  to word_byte.
- mem_rdata  in  DATA_W  from Read_data.
- busy  out  1  high in ISSUE and RESP.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE; gnt = 0; ack = 0; rsp_rdata = 0; rsp_err = 0; mem_cmd = 00; mem_addr = 0; mem_wdata = 0; mem_word_byte = 0; busy = 0; round-robin pointer = 0.
- States: IDLE, ISSUE, RESP.
- IDLE: if any req bit is high at a posedge, then at that edge:
  - select the first requester at or after the pointer (ascending index, wrapping);
  - latch its index, we, byte, addr and wdata;
  - set pointer = (index+1) mod NUM_REQ;
  - go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE (exactly one cycle):
  - gnt[index] = 1;
  - mem_cmd = 01 if we, else 10;
  - mem_addr, mem_wdata and mem_word_byte come from the latched registers.
  - The memory performs a read at the mid-cycle negedge, or a write at the closing posedge.
  - At the closing posedge: capture mem_rdata into rsp_rdata (loads only; stores leave rsp_rdata unchanged), then go to RESP.
- RESP (one cycle):
  - ack[index] = 1; mem_cmd = 00.
  - Arbitration runs exactly as in IDLE: any req bit high means the next state is ISSUE, otherwise IDLE.
  - Back-to-back throughput is therefore one access per 2 cycles.
- Latency: req first seen at posedge k → ISSUE during cycle k+1 → ack during cycle k+2.
- Request fields only need to be stable at the granting edge; the requester drops or changes req after seeing gnt.
  - A req still high in the RESP cycle is treated as a new request.
- Byte load: rsp_rdata = zero-extended mem[addr].
- Byte store: writes wdata[7:0].
- Word access: big-endian; addr holds bits [31:24].
- mem_cmd is never 11 and is 00 outside ISSUE.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N-1,0; no requester waits more than NUM_REQ grants.
- Reset mid-ISSUE: mem_cmd drops to 00 asynchronously, so no write commits at the following edge and no ack is issued. The interrupted requester must re-request.

Optional Feature:
- Macro: DMEM_ARB_CHECK_EN.
- Defined: a request is illegal if it is a word access with addr[1:0] != 0, or if addr+size > MEM_BYTES (size = 4 for word, 1 for byte).
  - Illegal requests pass through ISSUE with mem_cmd = 00, so memory is untouched.
  - In RESP: ack is given with rsp_err = 1, and rsp_rdata is left unchanged.
- Undefined: no check; rsp_err is tied to 0 and every request reaches memory.

Decomposition:
- Package/include dmem_arb_pkg holds:
  - state encodings: IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  - mem_cmd constants: CMD_IDLE = 2'b00, CMD_WRITE = 2'b01, CMD_READ = 2'b10.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, pointer;
  - outputs: one-hot winner, winner index, any.
  - Purely combinational; the pointer register stays in dmem_arbiter.

Test Plan:
- Reset release, req0 word load addr 0 → gnt[0] in cycle k+1 with mem_cmd = 10; ack[0] in k+2 with rsp_rdata = 0x00000004 (initial image).
- req1 word store addr 8, data 0xDEADBEEF, then req1 byte load addr 9 → second ack returns rsp_rdata = 0x000000AD.
- req0 and req1 both held high for 8 accesses → gnt sequence 0,1,0,1,...; acks spaced 2 cycles apart; mem_cmd never 11.
- rst_n pulsed low mid-ISSUE of a store to addr 12 → mem_cmd = 00 immediately, no ack; a later load of addr 12 returns 0x00000010.
- With DMEM_ARB_CHECK_EN: word load addr 2 → ack with rsp_err = 1 and mem_cmd stays 00. Byte store addr 31 succeeds with rsp_err = 0. Word store addr 29 → rsp_err = 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encodings
// and the memory command bus values.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  function automatic logic [1:0] cmd_for(input logic we);
    return we ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: selects the first requester at or after
// the pointer, scanning in ascending index order with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_win_oh,
  output logic [IDX_W-1:0]   o_win_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_j;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    o_any     = |i_req;
    w_j       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_j = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      if (i_req[w_j]) begin
        o_win_oh       = '0;
        o_win_oh[w_j]  = 1'b1;
        o_win_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port big-endian data memory among
// NUM_REQ requesters. Optional request legality check: DMEM_ARB_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_byte,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [1:0]                mem_cmd,
  output logic                      mem_word_byte,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, r_idx, w_win_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_win_oh, w_idx_oh;
  logic                w_any, w_grant;
  logic                r_we, r_byte, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_sel_we, w_sel_byte;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_chk_en, w_illegal;
  logic [ADDR_W:0]     w_end;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  // Arbitration is open in IDLE and RESP, closed only during ISSUE.
  assign w_grant   = w_any && (r_state != ISSUE);
  assign w_ptr_nxt = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
  assign w_idx_oh  = NUM_REQ'(1) << r_idx;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_byte  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_sel_we    = req_we[i];
        w_sel_byte  = req_byte[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef DMEM_ARB_CHECK_EN
  assign w_chk_en = 1'b1;
`else
  assign w_chk_en = 1'b0;
`endif

  // Extra top bit keeps addr+size from wrapping near the top of the address space.
  assign w_end     = {1'b0, w_sel_addr} + (ADDR_W+1)'(w_sel_byte ? 1 : 4);
  assign w_illegal = w_chk_en &&
                     ((!w_sel_byte && (w_sel_addr[1:0] != 2'b00)) ||
                      (w_end > (ADDR_W+1)'(MEM_BYTES)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    gnt           = '0;
    ack           = '0;
    mem_cmd       = CMD_IDLE;
    mem_addr      = r_addr;
    mem_wdata     = r_wdata;
    mem_word_byte = r_byte;
    busy          = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_grant ? ISSUE : IDLE;
      end
      ISSUE: begin
        gnt         = w_idx_oh;
        busy        = 1'b1;
        mem_cmd     = r_err ? CMD_IDLE : cmd_for(r_we);
        w_state_nxt = RESP;
      end
      RESP: begin
        ack         = w_idx_oh;
        busy        = 1'b1;
        w_state_nxt = w_grant ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the winner at the granting edge; capture load data as ISSUE closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr   <= w_ptr_nxt;
        r_idx   <= w_win_idx;
        r_we    <= w_sel_we;
        r_byte  <= w_sel_byte;
        r_err   <= w_illegal;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ISSUE) begin
        rsp_err <= r_err;
        if (!r_we && !r_err)
          rsp_rdata <= r_byte ? {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-byte big-endian memory model;
// extra vectors run when DMEM_ARB_CHECK_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, req_we = '0, req_byte = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  gnt, ack;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_cmd;
  logic        mem_word_byte;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  logic [7:0]  mem [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    int          id;
    logic        we;
    logic        bsel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];
  vec_t ctbl [5];

  dmem_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .MEM_BYTES(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_cmd(mem_cmd), .mem_word_byte(mem_word_byte),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: write on posedge, read on negedge, word_byte=1 means byte.
  always @(posedge clk) begin
    if (mem_cmd == 2'b01) begin
      if (mem_word_byte) begin
        mem[mem_addr[4:0]] <= mem_wdata[7:0];
      end else begin
        mem[mem_addr[4:0]]         <= mem_wdata[31:24];
        mem[mem_addr[4:0] + 5'd1]  <= mem_wdata[23:16];
        mem[mem_addr[4:0] + 5'd2]  <= mem_wdata[15:8];
        mem[mem_addr[4:0] + 5'd3]  <= mem_wdata[7:0];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_cmd == 2'b10) begin
      if (mem_word_byte)
        mem_rdata <= {24'h0, mem[mem_addr[4:0]]};
      else
        mem_rdata <= {mem[mem_addr[4:0]], mem[mem_addr[4:0] + 5'd1],
                      mem[mem_addr[4:0] + 5'd2], mem[mem_addr[4:0] + 5'd3]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_xact(input vec_t v);
    logic [1:0] oh;
    logic [1:0] exp_cmd;
    oh      = 2'b01 << v.id;
    exp_cmd = v.exp_err ? 2'b00 : (v.we ? 2'b01 : 2'b10);
    req                       = '0;
    req[v.id]                 = 1'b1;
    req_we[v.id]              = v.we;
    req_byte[v.id]            = v.bsel;
    req_addr[v.id*32 +: 32]   = v.addr;
    req_wdata[v.id*32 +: 32]  = v.wdata;
    tick();
    chk("issue_gnt", 32'(gnt), 32'(oh));
    chk("issue_cmd", 32'(mem_cmd), 32'(exp_cmd));
    chk("issue_ack", 32'(ack), 32'h0);
    chk("issue_busy", 32'(busy), 32'h1);
    chk("issue_addr", mem_addr, v.addr);
    chk("issue_wb", 32'(mem_word_byte), 32'(v.bsel));
    if (v.we) chk("issue_wdata", mem_wdata, v.wdata);
    req = '0;
    tick();
    chk("resp_ack", 32'(ack), 32'(oh));
    chk("resp_gnt", 32'(gnt), 32'h0);
    chk("resp_cmd", 32'(mem_cmd), 32'h0);
    chk("resp_rdata", rsp_rdata, v.exp_rdata);
    chk("resp_err", 32'(rsp_err), 32'(v.exp_err));
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_ack", 32'(ack), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Initial image: word at 4i holds 4i+4.
    for (int i = 0; i < 8; i++) begin
      mem[4*i]     = 8'h00;
      mem[4*i + 1] = 8'h00;
      mem[4*i + 2] = 8'h00;
      mem[4*i + 3] = 8'(4*i + 4);
    end

    tbl[0] = '{0, 1'b0, 1'b0, 32'd0, 32'h0,        32'h00000004, 1'b0};
    tbl[1] = '{1, 1'b1, 1'b0, 32'd8, 32'hDEADBEEF, 32'h00000004, 1'b0};
    tbl[2] = '{1, 1'b0, 1'b1, 32'd9, 32'h0,        32'h000000AD, 1'b0};
    tbl[3] = '{0, 1'b0, 1'b0, 32'd8, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[4] = '{0, 1'b1, 1'b1, 32'd4, 32'h12345655, 32'hDEADBEEF, 1'b0};
    tbl[5] = '{1, 1'b0, 1'b0, 32'd4, 32'h0,        32'h55000008, 1'b0};
    tbl[6] = '{1, 1'b0, 1'b1, 32'd7, 32'h0,        32'h00000008, 1'b0};

    ctbl[0] = '{0, 1'b0, 1'b0, 32'd2,  32'h0,        32'h00000010, 1'b1};
    ctbl[1] = '{1, 1'b1, 1'b1, 32'd31, 32'h000000A5, 32'h00000010, 1'b0};
    ctbl[2] = '{0, 1'b1, 1'b0, 32'd29, 32'h11223344, 32'h00000010, 1'b1};
    ctbl[3] = '{1, 1'b0, 1'b1, 32'd31, 32'h0,        32'h000000A5, 1'b0};
    ctbl[4] = '{0, 1'b0, 1'b0, 32'd28, 32'h0,        32'h000000A5, 1'b0};

    // Reset values
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_cmd", 32'(mem_cmd), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wb", 32'(mem_word_byte), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) do_xact(tbl[i]);

    // Both requesters held: grants alternate, pointer starts at 0 after r1 last won.
    req       = 2'b11;
    req_we    = 2'b00;
    req_byte  = 2'b00;
    req_addr  = {32'd16, 32'd0};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(2'b01 << (k % 2)));
      chk("rr_cmd", 32'(mem_cmd), 32'h2);
      chk("rr_cmd_legal", 32'(mem_cmd == 2'b11), 32'h0);
      tick();
      chk("rr_ack", 32'(ack), 32'(2'b01 << (k % 2)));
      chk("rr_rdata", rsp_rdata, (k % 2) ? 32'h00000014 : 32'h00000004);
      chk("rr_cmd_resp", 32'(mem_cmd), 32'h0);
      if (k == 7) req = '0;
    end
    tick();
    chk("rr_done_busy", 32'(busy), 32'h0);

    // Reset asserted mid-ISSUE of a store to addr 12
    req       = 2'b01;
    req_we    = 2'b01;
    req_byte  = 2'b00;
    req_addr  = {32'd0, 32'd12};
    req_wdata = {32'd0, 32'hCAFEF00D};
    tick();
    chk("mid_cmd_pre", 32'(mem_cmd), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_cmd_rst", 32'(mem_cmd), 32'h0);
    chk("mid_gnt_rst", 32'(gnt), 32'h0);
    chk("mid_busy_rst", 32'(busy), 32'h0);
    req = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_ack0", 32'(ack), 32'h0);
    chk("mid_rdata_rst", rsp_rdata, 32'h0);
    tick();
    chk("mid_ack1", 32'(ack), 32'h0);
    do_xact('{1, 1'b0, 1'b0, 32'd12, 32'h0, 32'h00000010, 1'b0});

`ifdef DMEM_ARB_CHECK_EN
    for (int i = 0; i < 5; i++) do_xact(ctbl[i]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
